hatch_fetch: RTL

- Instruction-fetch front end between the 256 x 48-bit hatch instruction memory and the CPU decode stage.
- Walks a byte PC in 6-byte steps and issues synchronous reads to the memory by word index (PC / 6).
- Buffers returned 48-bit instructions in a small prefetch FIFO.
- Hands instructions to the CPU over a valid/ready handshake; flushes on branch redirect.

---
 rtl/hatch_pkg.sv | 24 ++
 rtl/hatch_fetch_fifo.sv | 73 +++++++
 rtl/hatch_fetch.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/hatch_pkg.sv
`default_nettype none
// ============================================================================
// Module   : hatch_pkg
// Brief    : Shared widths, fetch state encoding and FIFO entry layout for the
//            hatch instruction-fetch front end.
// Revision : 1.0
// ============================================================================
package hatch_pkg;

    localparam int INSN_W     = 48;
    localparam int INSN_BYTES = 6;

    typedef enum logic [0:0] {
        RUN  = 1'b0,
        HALT = 1'b1
    } fetch_state_t;

    typedef struct packed {
        logic [INSN_W-1:0] insn;
        logic [31:0]       pc;
    } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/hatch_fetch_fifo.sv
`default_nettype none
// ============================================================================
// Module   : hatch_fetch_fifo
// Brief    : Synchronous prefetch FIFO with flush; push and pop may coincide at
//            any occupancy, including full.
// Revision : 1.0
// ============================================================================
module hatch_fetch_fifo
    import hatch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   push,
    input  fetch_entry_t           push_data,
    input  logic                   pop,
    output fetch_entry_t           head,
    output logic [$clog2(DEPTH):0] count,
    output logic                   empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] C_FULL = CW'(DEPTH);

    fetch_entry_t  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          w_pop;
    logic          w_push;

    assign empty  = (r_count == '0);
    assign count  = r_count;
    assign head   = r_mem[r_rd_ptr];
    assign w_pop  = pop && !empty;
    // A pop in the same cycle frees the slot a full FIFO needs for the push.
    assign w_push = push && ((r_count != C_FULL) || w_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push && !flush) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

endmodule
`default_nettype wire

// File: rtl/hatch_fetch.sv
`default_nettype none
// ============================================================================
// Module   : hatch_fetch
// Brief    : Instruction-fetch front end: walks a byte PC in 6-byte steps,
//            reads the 48-bit instruction memory, buffers and hands off to the
//            CPU. Optional bounds checking under HATCH_FETCH_BOUNDS_EN.
// Revision : 1.0
// ============================================================================
module hatch_fetch
    import hatch_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter int          IDX_W    = 8,
    parameter logic [31:0] RESET_PC = 32'd0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              redirect_valid,
    input  logic [31:0]       redirect_addr,
    output logic              mem_rd,
    output logic [IDX_W-1:0]  mem_index,
    input  logic [INSN_W-1:0] mem_data,
    output logic              insn_valid,
    input  logic              insn_ready,
    output logic [INSN_W-1:0] insn_data,
    output logic [31:0]       insn_pc,
    output logic              misalign,
    output logic              fault
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int OW = CW + 1;
    localparam logic [IDX_W-1:0] C_RESET_IDX = IDX_W'(RESET_PC / 32'(INSN_BYTES));

    fetch_state_t     r_state;
    fetch_state_t     w_state_nxt;
    logic [31:0]      r_fetch_pc;
    logic [IDX_W-1:0] r_fetch_idx;
    logic             r_inflight;
    logic [31:0]      r_inflight_pc;
    logic             r_misalign;
    logic             r_fault;
    fetch_entry_t     r_hold;
    fetch_entry_t     w_head;
    fetch_entry_t     w_push_entry;
    logic [CW-1:0]    w_count;
    logic             w_empty;
    logic             w_issue;
    logic             w_room;
    logic             w_tgt_aligned;
    logic             w_tgt_oob;
    logic             w_at_end;
    logic [IDX_W-1:0] w_tgt_idx;

    assign w_tgt_aligned = ((redirect_addr % 32'(INSN_BYTES)) == 32'd0);

`ifdef HATCH_FETCH_BOUNDS_EN
    localparam logic [IDX_W-1:0] C_LAST_IDX = '1;
    logic [31:0] w_tgt_word;

    assign w_tgt_word = redirect_addr / 32'(INSN_BYTES);
    assign w_tgt_idx  = w_tgt_word[IDX_W-1:0];
    assign w_tgt_oob  = ((w_tgt_word >> IDX_W) != 32'd0);
    assign w_at_end   = (r_fetch_idx == C_LAST_IDX);
`else
    assign w_tgt_idx  = IDX_W'(redirect_addr / 32'(INSN_BYTES));
    assign w_tgt_oob  = 1'b0;
    assign w_at_end   = 1'b0;
`endif

    // Credit check counts the read still in flight so the FIFO never overflows.
    assign w_room = (({1'b0, w_count} + OW'(r_inflight)) < OW'(DEPTH));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_issue     = 1'b0;
        if (redirect_valid) begin
            w_state_nxt = (w_tgt_aligned && !w_tgt_oob) ? RUN : HALT;
        end else if ((r_state == RUN) && w_room && !rst) begin
            w_issue = 1'b1;
            // The last word is still fetched; only the wrap beyond it is refused.
            if (w_at_end) begin
                w_state_nxt = HALT;
            end
        end
    end

    assign mem_rd    = w_issue;
    assign mem_index = r_fetch_idx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fetch_pc    <= RESET_PC;
            r_fetch_idx   <= C_RESET_IDX;
            r_inflight    <= 1'b0;
            r_inflight_pc <= '0;
            r_misalign    <= 1'b0;
            r_fault       <= 1'b0;
            r_hold        <= '0;
        end else begin
            if (redirect_valid) begin
                r_inflight <= 1'b0;
                if (w_tgt_aligned) begin
                    r_misalign  <= 1'b0;
                    r_fault     <= w_tgt_oob;
                    r_fetch_pc  <= redirect_addr;
                    r_fetch_idx <= w_tgt_idx;
                end else begin
                    r_misalign  <= 1'b1;
                    r_fault     <= r_fault | w_tgt_oob;
                end
            end else begin
                r_inflight <= w_issue;
                if (w_issue) begin
                    r_inflight_pc <= r_fetch_pc;
                    r_fetch_pc    <= r_fetch_pc + 32'(INSN_BYTES);
                    r_fetch_idx   <= r_fetch_idx + IDX_W'(1);
                    if (w_at_end) begin
                        r_fault <= 1'b1;
                    end
                end
            end
            if (insn_valid) begin
                r_hold <= w_head;
            end
        end
    end

    // Data returning in a redirect cycle belongs to the abandoned stream.
    assign w_push_entry = '{insn: mem_data, pc: r_inflight_pc};

    hatch_fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (redirect_valid),
        .push      (r_inflight && !redirect_valid),
        .push_data (w_push_entry),
        .pop       (insn_ready),
        .head      (w_head),
        .count     (w_count),
        .empty     (w_empty)
    );

    assign insn_valid = !w_empty;
    assign insn_data  = insn_valid ? w_head.insn : r_hold.insn;
    assign insn_pc    = insn_valid ? w_head.pc   : r_hold.pc;
    assign misalign   = r_misalign;
    assign fault      = r_fault;

endmodule
`default_nettype wire
